// File: rtl/car_sensor_emulator.sv
// Car-park sensor emulator: on an accepted entry/exit request it drives the
// outer/inner beam outputs through the matching 3-phase pattern, waits out a
// quiet gap and counts completed events per direction (saturating).
module car_sensor_emulator #(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_dir,
  output logic             req_ready,
  input  logic             abort,
  output logic             sensor_a,
  output logic             sensor_b,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] entry_count,
  output logic [CNT_W-1:0] exit_count
);

  // The dwell counter only ever reaches (limit - 1) of the longer of the two phases.
  localparam int unsigned MaxLim = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned DwW    = (MaxLim > 1) ? $clog2(MaxLim) : 1;
  localparam logic [DwW-1:0] DwellLast = DwW'(DWELL_CYCLES - 1);
  localparam logic [DwW-1:0] GapLast   = DwW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [2:0] {
    StIdle,
    StPh1,
    StPh2,
    StPh3,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [DwW-1:0]   dwell_q, dwell_d;
  logic             dir_q, dir_d;
  logic             complete;
  logic             cancel;

  logic             sensor_a_q, sensor_a_d;
  logic             sensor_b_q, sensor_b_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [CNT_W-1:0] entry_count_q, entry_count_d;
  logic [CNT_W-1:0] exit_count_q, exit_count_d;

  // State, dwell counter and latched direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      dwell_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state: accept in idle, advance phases on dwell expiry, abort wins over advance.
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q + DwW'(1);
    dir_d    = dir_q;
    complete = 1'b0;
    cancel   = 1'b0;
    unique case (state_q)
      StIdle: begin
        dwell_d = '0;
        if (req_valid) begin
          state_d = StPh1;
          dir_d   = req_dir;
        end
      end
      StPh1: begin
        if (dwell_q == DwellLast) begin
          state_d = StPh2;
          dwell_d = '0;
        end
      end
      StPh2: begin
        if (dwell_q == DwellLast) begin
          state_d = StPh3;
          dwell_d = '0;
        end
      end
      StPh3: begin
        if (dwell_q == DwellLast) begin
          dwell_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d  = StIdle;
            complete = 1'b1;
          end else begin
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (dwell_q == GapLast) begin
          state_d  = StIdle;
          dwell_d  = '0;
          complete = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        dwell_d = '0;
      end
    endcase
    if (abort && (state_q != StIdle)) begin
      state_d  = StIdle;
      dwell_d  = '0;
      complete = 1'b0;
      cancel   = 1'b1;
    end
  end

  // Output next-values derived from the upcoming state so every output is a flop.
  always_comb begin
    sensor_a_d = 1'b0;
    sensor_b_d = 1'b0;
    case (state_d)
      StPh1: begin
        sensor_a_d = ~dir_d;
        sensor_b_d = dir_d;
      end
      StPh2: begin
        sensor_a_d = 1'b1;
        sensor_b_d = 1'b1;
      end
      StPh3: begin
        sensor_a_d = dir_d;
        sensor_b_d = ~dir_d;
      end
      default: begin
        sensor_a_d = 1'b0;
        sensor_b_d = 1'b0;
      end
    endcase
    req_ready_d   = (state_d == StIdle);
    busy_d        = (state_d != StIdle);
    done_d        = complete;
    aborted_d     = cancel;
    entry_count_d = entry_count_q;
    exit_count_d  = exit_count_q;
    if (complete && !dir_q && (entry_count_q != CntMax)) begin
      entry_count_d = entry_count_q + CNT_W'(1);
    end
    if (complete && dir_q && (exit_count_q != CntMax)) begin
      exit_count_d = exit_count_q + CNT_W'(1);
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sensor_a_q    <= 1'b0;
      sensor_b_q    <= 1'b0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      entry_count_q <= '0;
      exit_count_q  <= '0;
    end else begin
      sensor_a_q    <= sensor_a_d;
      sensor_b_q    <= sensor_b_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      entry_count_q <= entry_count_d;
      exit_count_q  <= exit_count_d;
    end
  end

  assign sensor_a    = sensor_a_q;
  assign sensor_b    = sensor_b_q;
  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign entry_count = entry_count_q;
  assign exit_count  = exit_count_q;

endmodule

// File: tb/tb_car_sensor_emulator.sv
// Bench for car_sensor_emulator: vector table, hand-written corner sequences,
// randomized traffic against a timeline-based reference model, and a
// saturation/zero-gap run on a second small instance.
module tb_car_sensor_emulator;

  localparam int unsigned D   = 4;
  localparam int unsigned G   = 2;
  localparam int unsigned SD  = 2;
  localparam int unsigned SG  = 0;
  localparam int unsigned SCW = 2;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_dir, abort;
  logic req_ready, sensor_a, sensor_b, busy, done, aborted;
  logic [7:0] entry_count, exit_count;

  logic s_valid, s_dir, s_abort;
  logic s_ready, s_a, s_b, s_busy, s_done, s_aborted;
  logic [SCW-1:0] s_entry, s_exit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  car_sensor_emulator #(.DWELL_CYCLES(D), .GAP_CYCLES(G), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_dir(req_dir),
    .req_ready(req_ready), .abort(abort), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .busy(busy), .done(done), .aborted(aborted), .entry_count(entry_count),
    .exit_count(exit_count)
  );

  car_sensor_emulator #(.DWELL_CYCLES(SD), .GAP_CYCLES(SG), .CNT_W(SCW)) dut_sat (
    .clk(clk), .reset(reset), .req_valid(s_valid), .req_dir(s_dir),
    .req_ready(s_ready), .abort(s_abort), .sensor_a(s_a), .sensor_b(s_b),
    .busy(s_busy), .done(s_done), .aborted(s_aborted), .entry_count(s_entry),
    .exit_count(s_exit)
  );

  typedef struct {
    logic       v;
    logic       d;
    logic       ab;
    int         reps;
    logic [1:0] sens;
    logic       rdy;
    logic       dn;
    logic       abd;
    int         ent;
    int         ext;
  } vec_t;

  vec_t tbl[$];

  // Model: a request timeline (edges since acceptance) rather than a state machine.
  bit m_busy, m_dir, m_done, m_ab;
  int m_n, m_ent, m_ext;

  function automatic logic [21:0] actual_vec();
    return {sensor_a, sensor_b, req_ready, busy, done, aborted, entry_count, exit_count};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic d, input logic ab, input int reps,
                     input logic [1:0] s, input logic rdy, input logic dn, input logic abd,
                     input int ent, input int ext);
    vec_t r;
    r.v = v; r.d = d; r.ab = ab; r.reps = reps; r.sens = s;
    r.rdy = rdy; r.dn = dn; r.abd = abd; r.ent = ent; r.ext = ext;
    tbl.push_back(r);
  endtask

  task automatic step(input logic v, input logic d, input logic ab);
    @(negedge clk);
    req_valid = v;
    req_dir   = d;
    abort     = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b0; req_dir = 1'b0; abort = 1'b0;
    s_valid = 1'b0; s_dir = 1'b0; s_abort = 1'b0;
    #2;
    reset = 1'b0;
    m_busy = 0; m_dir = 0; m_done = 0; m_ab = 0; m_n = 0; m_ent = 0; m_ext = 0;
  endtask

  function automatic logic [1:0] model_pattern();
    int phase;
    if (!m_busy) return 2'b00;
    phase = m_n / int'(D);
    case (phase)
      0:       return m_dir ? 2'b01 : 2'b10;
      1:       return 2'b11;
      2:       return m_dir ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_step(input logic v, input logic d, input logic ab);
    m_done = 0;
    m_ab   = 0;
    if (!m_busy) begin
      if (v) begin
        m_busy = 1; m_n = 0; m_dir = d;
      end
    end else if (ab) begin
      m_busy = 0; m_ab = 1;
    end else begin
      m_n++;
      if (m_n == int'(3 * D + G)) begin
        m_busy = 0; m_done = 1;
        if (m_dir) m_ext = (m_ext < 255) ? m_ext + 1 : 255;
        else       m_ent = (m_ent < 255) ? m_ent + 1 : 255;
      end
    end
  endtask

  initial begin
    logic [21:0] exp_v;
    int lat;
    int exp_cnt;

    // Entry event (test 1)
    add(1, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0);
    add(0, 0, 0, 3, 2'b10, 0, 0, 0, 0, 0);
    add(0, 0, 0, 4, 2'b11, 0, 0, 0, 0, 0);
    add(0, 0, 0, 4, 2'b01, 0, 0, 0, 0, 0);
    add(0, 0, 0, 2, 2'b00, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 2'b00, 1, 1, 0, 1, 0);
    // Exit event; req_dir toggled while busy must be ignored (test 2)
    add(1, 1, 0, 1, 2'b01, 0, 0, 0, 1, 0);
    add(0, 0, 0, 3, 2'b01, 0, 0, 0, 1, 0);
    add(0, 0, 0, 4, 2'b11, 0, 0, 0, 1, 0);
    add(0, 0, 0, 4, 2'b10, 0, 0, 0, 1, 0);
    add(0, 0, 0, 2, 2'b00, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 2'b00, 1, 1, 0, 1, 1);
    add(0, 0, 0, 1, 2'b00, 1, 0, 0, 1, 1);
    // Abort in idle coincides with acceptance; then abort on 2nd cycle of 11 (test 4)
    add(1, 0, 1, 1, 2'b10, 0, 0, 0, 1, 1);
    add(0, 0, 0, 3, 2'b10, 0, 0, 0, 1, 1);
    add(0, 0, 0, 2, 2'b11, 0, 0, 0, 1, 1);
    add(0, 0, 1, 1, 2'b00, 1, 0, 1, 1, 1);
    add(0, 0, 0, 1, 2'b00, 1, 0, 0, 1, 1);
    // Back-to-back with req_valid held: second acceptance while done=1 (test 3)
    add(1, 0, 0, 4, 2'b10, 0, 0, 0, 1, 1);
    add(1, 0, 0, 4, 2'b11, 0, 0, 0, 1, 1);
    add(1, 0, 0, 4, 2'b01, 0, 0, 0, 1, 1);
    add(1, 0, 0, 2, 2'b00, 0, 0, 0, 1, 1);
    add(1, 1, 0, 1, 2'b00, 1, 1, 0, 2, 1);
    add(1, 1, 0, 1, 2'b01, 0, 0, 0, 2, 1);
    add(0, 0, 0, 3, 2'b01, 0, 0, 0, 2, 1);
    add(0, 0, 0, 4, 2'b11, 0, 0, 0, 2, 1);
    add(0, 0, 0, 4, 2'b10, 0, 0, 0, 2, 1);
    add(0, 0, 0, 2, 2'b00, 0, 0, 0, 2, 1);
    add(0, 0, 0, 1, 2'b00, 1, 1, 0, 2, 2);

    reset = 1'b1;
    req_valid = 1'b0; req_dir = 1'b0; abort = 1'b0;
    s_valid = 1'b0; s_dir = 1'b0; s_abort = 1'b0;
    #1;
    check("reset_main", 32'(actual_vec()), 32'({2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0}));
    check("reset_sat", 32'({s_a, s_b, s_ready, s_busy, s_done, s_aborted, s_entry, s_exit}),
          32'({2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}));
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        step(tbl[i].v, tbl[i].d, tbl[i].ab);
        exp_v = {tbl[i].sens, tbl[i].rdy, ~tbl[i].rdy, tbl[i].dn, tbl[i].abd,
                 8'(tbl[i].ent), 8'(tbl[i].ext)};
        check($sformatf("tbl[%0d].%0d", i, r), 32'(actual_vec()), 32'(exp_v));
      end
    end

    // Asynchronous reset mid-PH3 (test 5)
    step(1, 0, 0);
    repeat (2 * D) step(0, 0, 0);
    check("ph3_before_reset", 32'({sensor_a, sensor_b}), 32'(2'b01));
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", 32'(actual_vec()), 32'({2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0}));
    @(negedge clk);
    reset = 1'b0;

    // Saturation and zero gap on the small instance (test 6)
    for (int e = 0; e < 5; e++) begin
      @(negedge clk);
      s_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("sat_accept%0d", e), 32'({s_busy, s_a, s_b}), 32'(3'b110));
      @(negedge clk);
      s_valid = 1'b0;
      lat = 0;
      while (s_done !== 1'b1 && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("sat_latency%0d", e), 32'(lat), 32'(3 * SD + SG));
      exp_cnt = (e + 1 < 3) ? e + 1 : 3;
      check($sformatf("sat_count%0d", e), 32'(s_entry), 32'(exp_cnt));
    end

    // Randomized traffic against the timeline model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic v, d, ab;
      v  = ($urandom_range(0, 3) != 0);
      d  = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 19) == 0);
      step(v, d, ab);
      model_step(v, d, ab);
      exp_v = {model_pattern(), ~m_busy, m_busy, m_done, m_ab, 8'(m_ent), 8'(m_ext)};
      check($sformatf("rand%0d", i), 32'(actual_vec()), 32'(exp_v));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/car_sensor_emulator.md
Name: car_sensor_emulator

Overview:
- Stimulus-side counterpart of the car-park entry/exit detector FSM: it generates the two-sensor beam sequences that the detector decodes into entered/exited.
- A requester asks for one "entry" or "exit" event through a valid/ready handshake. The block then drives sensor_a/sensor_b (the detector's btn[0]/btn[1]) through the correct 3-phase pattern with programmable dwell times, followed by a quiet gap.
- Completed events are counted, so the emulator can drive the detector in system-level tests and FPGA self-test.

Parameters:
DWELL_CYCLES, 4, clock cycles each sensor phase is held (legal range >= 1)
GAP_CYCLES, 2, cycles of sensors 00 after phase 3 before the next request is accepted (legal range >= 0)
CNT_W, 8, width of the entry/exit event counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  event request present
req_dir  in  1  0 = entry, 1 = exit; sampled only on acceptance
req_ready  out  1  block idle and able to accept a request
abort  in  1  synchronous cancel of an event in progress
sensor_a  out  1  outer beam, drives detector btn[0]
sensor_b  out  1  inner beam, drives detector btn[1]
busy  out  1  event in progress (equals ~req_ready)
done  out  1  one-cycle pulse when an event completes normally
aborted  out  1  one-cycle pulse when an event is cancelled
entry_count  out  CNT_W  completed entry events, saturating
exit_count  out  CNT_W  completed exit events, saturating

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, including mid-event):
  - state IDLE, sensor_a=0, sensor_b=0, req_ready=1, busy=0, done=0, aborted=0, both counts 0.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, PH1, PH2, PH3, GAP. The direction is latched into an internal dir register on acceptance.
- Sensor patterns as {a,b}:
  - Entry: PH1=10, PH2=11, PH3=01.
  - Exit: PH1=01, PH2=11, PH3=10.
  - IDLE and GAP = 00.
- Handshake:
  - Acceptance occurs at a rising edge where req_valid=1 and req_ready=1; this edge is t0. Acceptance is only possible in IDLE.
  - req_valid with req_ready=0 is ignored. No queuing; the requester holds req_valid until accepted.
- Timing with D=DWELL_CYCLES and G=GAP_CYCLES:
  - After t0: PH1 pattern visible, req_ready=0, busy=1.
  - After t0+D: PH2. After t0+2D: PH3. After t0+3D: GAP with sensors 00.
  - After t0+3D+G: IDLE, req_ready=1, done=1 for exactly one cycle.
  - If G=0, PH3 goes directly to IDLE at t0+3D.
- A dwell counter is cleared on every state entry; the state advances when the counter reaches the limit minus 1.
- Counters:
  - On the edge that asserts done, entry_count (dir=0) or exit_count (dir=1) increments.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- A new request may be accepted on the edge that returns to IDLE is not allowed; it is accepted on the first edge after that, while done is high. The minimum event-to-event spacing is therefore 3D+G+1 cycles.
- Abort:
  - abort=1 at an edge in PH1, PH2, PH3 or GAP: next state IDLE, sensors 00, aborted=1 for one cycle, done=0, no counter change.
  - abort in IDLE has no effect, even if it coincides with acceptance; the request is still accepted.
  - abort has priority over a phase advance at the same edge.
- req_dir changes while busy have no effect.

Test Plan:
1. Entry event: reset, then req_valid=1, req_dir=0 for one accepted cycle (D=4, G=2). Sensors must be 10 for 4 cycles, 11 for 4, 01 for 4, then 00. done pulses exactly 14 cycles after acceptance, entry_count=1, exit_count=0.
2. Exit event: req_dir=1. Sensors must be 01, then 11, then 10, each for 4 cycles. done follows, exit_count=1. Connecting the detector FSM must yield exited=1 and the detector returns to S0.
3. Back-to-back: req_valid held high for two requests (entry, then exit). The second acceptance occurs while done=1; acceptances are 15 cycles apart; final counts are 1/1.
4. Abort in PH2: assert abort on the 2nd cycle of 11. The next cycle must show sensors 00, aborted=1, done=0, counts unchanged, req_ready=1.
5. Asynchronous reset mid-PH3: assert reset between clock edges. Outputs must go to reset values immediately without waiting for an edge, and counts clear to 0.
6. Saturation with CNT_W=2: perform 5 entry events. entry_count must read 1, 2, 3, 3, 3.
